// File: rtl/uart_tx_fifo_if.sv
// Producer / transmitter-facing signal bundle for the uart_tx_fifo queue.
// master: the environment (byte producer plus UART transmitter status).
// slave : the queue itself.
interface uart_tx_fifo_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic [7:0]      din;
   logic            wr_en;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] count;
   logic            overflow;
   logic [7:0]      tx_din;
   logic            tx_wr_en;
   logic            tx_busy;
   logic            idle;

   modport master (
      output din, wr_en, tx_busy,
      input  full, empty, count, overflow, tx_din, tx_wr_en, idle
   );

   modport slave (
      input  din, wr_en, tx_busy,
      output full, empty, count, overflow, tx_din, tx_wr_en, idle
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte transmit queue feeding a UART transmitter. Bytes are pushed at full
// clock rate and drained one at a time through a one-cycle request, waiting
// for the transmitter's busy flag to rise and fall between bytes.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave bus
);
   localparam int unsigned     ADDR_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10
   } state_t;

   logic [7:0]      mem_q [DEPTH];
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      tx_din_q, tx_din_d;
   logic            tx_wr_en_q, tx_wr_en_d;
   state_t          state_q, state_d;

   logic [ADDR_W:0] count_w;
   logic            full_w;
   logic            empty_w;
   logic            push;
   logic            pop;

   // Occupancy flags come only from registered pointers; no path from wr_en.
   assign count_w = wr_ptr_q - rd_ptr_q;
   assign full_w  = (count_w == FULL_CNT);
   assign empty_w = (count_w == '0);

   // Push acceptance and sticky overflow, judged on the pre-edge full flag.
   always_comb begin
      push       = bus.wr_en && !full_w;
      wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      overflow_d = overflow_q | (bus.wr_en & full_w);
   end

   // Drain FSM next-state and registered-output values.
   always_comb begin
      state_d    = state_q;
      tx_din_d   = tx_din_q;
      tx_wr_en_d = 1'b0;
      pop        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty_w && !bus.tx_busy) begin
               tx_din_d   = mem_q[rd_ptr_q[ADDR_W-1:0]];
               tx_wr_en_d = 1'b1;
               pop        = 1'b1;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.tx_busy) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.tx_busy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
   end

   // Pointer, flag and drain-FSM registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         tx_din_q   <= '0;
         tx_wr_en_q <= 1'b0;
         state_q    <= S_IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         tx_din_q   <= tx_din_d;
         tx_wr_en_q <= tx_wr_en_d;
         state_q    <= state_d;
      end
   end

   // Byte storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.din;
      end
   end

   assign bus.count    = count_w;
   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.overflow = overflow_q;
   assign bus.tx_din   = tx_din_q;
   assign bus.tx_wr_en = tx_wr_en_q;
   assign bus.idle     = empty_w && (state_q == S_IDLE) && !bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: byte queue model, UART transmitter model and a
// per-cycle comparison of every output, plus directed literal checks.
module tb_uart_tx_fifo;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
   uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int vectors = 0;
   int errors  = 0;

   // Transmitter model state.
   logic xbusy     = 1'b0;
   logic hold_busy = 1'b0;
   int   pend      = 0;
   int   remain    = 0;
   int   tx_delay  = 1;
   int   frame_lo  = 4;
   int   frame_hi  = 4;
   bit   rnd_delay = 1'b0;
   assign bus.tx_busy = xbusy | hold_busy;

   // Reference model: byte queue plus handshake flags.
   byte unsigned mq[$];
   bit           m_ovf  = 1'b0;
   bit           m_free = 1'b1;  // no request outstanding
   bit           m_seen = 1'b0;  // busy observed high since last request
   bit           m_wr   = 1'b0;
   byte unsigned m_din  = 8'h00;
   bit           chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model update at each active edge from pre-edge inputs.
   always @(posedge clk) begin
      bit pop_now;
      bit was_full;
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_free = 1'b1;
         m_seen = 1'b0;
         m_wr   = 1'b0;
         m_din  = 8'h00;
      end else begin
         was_full = (mq.size() == DEPTH);
         pop_now  = m_free && (mq.size() != 0) && !bus.tx_busy;
         if (bus.wr_en && was_full) m_ovf = 1'b1;
         if (!m_free) begin
            if (bus.tx_busy) m_seen = 1'b1;
            else if (m_seen) m_free = 1'b1;
         end
         m_wr = pop_now;
         if (pop_now) begin
            m_din  = mq.pop_front();
            m_free = 1'b0;
            m_seen = 1'b0;
         end
         if (bus.wr_en && !was_full) mq.push_back(bus.din);
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("count",    bus.count,    mq.size());
         chk("empty",    bus.empty,    mq.size() == 0);
         chk("full",     bus.full,     mq.size() == DEPTH);
         chk("overflow", bus.overflow, m_ovf);
         chk("tx_wr_en", bus.tx_wr_en, m_wr);
         chk("tx_din",   bus.tx_din,   m_din);
         chk("idle",     bus.idle,     (mq.size() == 0) && m_free && !bus.tx_busy);
      end
   end

   // UART transmitter model: busy rises tx_delay cycles after a request.
   always @(negedge clk) begin
      if (bus.tx_wr_en) begin
         chk("req_while_busy", {30'd0, (pend != 0), xbusy}, 0);
         pend = rnd_delay ? $urandom_range(3, 1) : tx_delay;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            xbusy  = 1'b1;
            remain = $urandom_range(frame_hi, frame_lo);
         end
      end else if (xbusy) begin
         if (remain <= 1) xbusy = 1'b0;
         else remain--;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_count",    bus.count,    0);
      chk("rst_empty",    bus.empty,    1);
      chk("rst_full",     bus.full,     0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_tx_wr_en", bus.tx_wr_en, 0);
      step();
      rst = 1'b0;
   endtask

   task automatic push_seq(input int n, input byte unsigned base);
      for (int i = 0; i < n; i++) begin
         step();
         bus.wr_en = 1'b1;
         bus.din   = base + 8'(i);
      end
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int bound);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.idle && n < bound);
      chk(nm, bus.idle, 1);
   endtask

   initial begin
      int  n;
      int  guard;
      bit  saw;
      bus.din   = 8'h00;
      bus.wr_en = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("init_count", bus.count, 0);
      chk("init_tx_din", bus.tx_din, 8'h00);
      step();
      rst = 1'b0;

      // Single byte with a realistic 10 x 234 clock frame.
      frame_lo = 2340;
      frame_hi = 2340;
      step();
      bus.wr_en = 1'b1;
      bus.din   = 8'hA5;
      @(posedge clk);
      #1;
      chk("single_no_req_yet", bus.tx_wr_en, 0);
      chk("single_count1", bus.count, 1);
      step();
      bus.wr_en = 1'b0;
      @(posedge clk);
      #1;
      chk("single_req", bus.tx_wr_en, 1);
      chk("single_din", bus.tx_din, 8'hA5);
      chk("single_empty", bus.empty, 1);
      @(posedge clk);
      #1;
      chk("single_req_len", bus.tx_wr_en, 0);
      chk("single_din_hold", bus.tx_din, 8'hA5);
      wait_idle("single_idle", 3000);

      // Burst of 16 consecutive pushes; one pops early so full never asserts.
      frame_lo = 3;
      frame_hi = 8;
      saw      = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         saw       = saw | bus.full;
         bus.wr_en = 1'b1;
         bus.din   = 8'(i);
      end
      step();
      saw       = saw | bus.full;
      bus.wr_en = 1'b0;
      chk("burst_never_full", saw, 0);
      wait_idle("burst_idle", 2000);

      // Slow busy: transmitter takes 5 cycles to raise busy.
      tx_delay = 5;
      push_seq(3, 8'h60);
      wait_idle("slow_idle", 500);
      tx_delay = 1;

      // Push exactly on pop cycles across pointer wrap.
      do_reset();
      frame_lo  = 2;
      frame_hi  = 4;
      hold_busy = 1'b1;
      push_seq(15, 8'h10);
      chk("wrap_prefill", bus.count, 15);
      hold_busy = 1'b0;
      n     = 0;
      guard = 0;
      while (n < 40 && guard < 5000) begin
         step();
         if (m_free && mq.size() != 0 && !bus.tx_busy) begin
            bus.wr_en = 1'b1;
            bus.din   = 8'h80 + 8'(n);
            n++;
         end else begin
            bus.wr_en = 1'b0;
         end
         guard++;
      end
      step();
      bus.wr_en = 1'b0;
      chk("wrap_pushes", n, 40);
      wait_idle("wrap_idle", 2000);
      chk("wrap_no_overflow", bus.overflow, 0);

      // Overflow with transmitter held busy.
      hold_busy = 1'b1;
      push_seq(17, 8'h40);
      chk("ovf_count", bus.count, 16);
      chk("ovf_full", bus.full, 1);
      chk("ovf_flag", bus.overflow, 1);
      hold_busy = 1'b0;
      wait_idle("ovf_idle", 2000);
      chk("ovf_sticky", bus.overflow, 1);
      chk("ovf_drained", bus.count, 0);

      // Reset mid-stream with the transmitter busy.
      hold_busy = 1'b1;
      push_seq(8, 8'hC0);
      chk("mid_count8", bus.count, 8);
      do_reset();
      push_seq(1, 8'h3C);
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         saw = saw | bus.tx_wr_en;
      end
      chk("mid_no_req_while_busy", saw, 0);
      hold_busy = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.tx_wr_en && n < 50);
      chk("mid_req", bus.tx_wr_en, 1);
      chk("mid_din", bus.tx_din, 8'h3C);
      wait_idle("mid_idle", 500);

      // Randomised traffic with random frame length and busy latency.
      frame_lo  = 1;
      frame_hi  = 12;
      rnd_delay = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step();
         bus.wr_en = ($urandom_range(99, 0) < 40);
         bus.din   = 8'($urandom);
      end
      step();
      bus.wr_en = 1'b0;
      wait_idle("rand_idle", 5000);
      rnd_delay = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
